wb_req_master: RTL
==================

WB_REQ_MASTER -- requirements
Module: wb_req_master

Interface
REQ-001 Parameter AW, default 23: Wishbone word-address width; request halfword address is AW+1 bits.
REQ-002 clk_i  in  1  single system clock; one clock, all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 req_valid/req_ready  in/out  1/1  request handshake; transfer when both high on a clock edge.
REQ-005 req_addr  in  AW+1  start halfword address; req_len  in  4  halfword count; req_we  in  1  1=write.
REQ-006 din  in  16  write halfword; din_mask  in  2  byte enables (1=write byte); din_valid/din_ready  in/out  1/1.
REQ-007 dout  out  16  read halfword; dout_valid  out  1  one halfword per high cycle, no backpressure.
REQ-008 cyc_o, stb_o, we_o  out  1  Wishbone classic master controls; adr_o  out  AW  word address.
REQ-009 dat_o  out  32  write data; sel_o  out  4  byte selects; dat_i  in  32  read data; ack_i  in  1  slave ack.

Function
REQ-010 States: IDLE, WFILL, WBUS, RBUS, RHI, GAP; req_ready=1 only in IDLE.
REQ-011 On request accept: latch addr, len, we; len=0 -> remain IDLE, no bus cycle.
REQ-012 Word address = addr[AW:1]; halfword addr[0]=0 -> bits[15:0]/sel[1:0], addr[0]=1 -> bits[31:16]/sel[3:2].
REQ-013 Write: WFILL asserts din_ready; each din beat loads its half of dat_o and sel bits from din_mask, addr+1, len-1.
REQ-014 Write: transition WFILL->WBUS after high half loaded or len reaches 0; untouched half has sel bits 0.
REQ-015 WBUS: cyc_o=stb_o=we_o=1, adr_o/dat_o/sel_o stable until ack_i sampled high.
REQ-016 Read: RBUS drives cyc_o=stb_o=1, we_o=0, sel_o=4'hF, adr_o of current word; held until ack_i.
REQ-017 Read ack: register dat_i; next cycle dout_valid=1 with half at addr[0], addr+1, len-1.
REQ-018 Read: if addr[0] was 0 and len remains, RHI emits bits[31:16] next cycle (dout_valid=1), addr+1, len-1.
REQ-019 After each ack: cyc_o/stb_o low the cycle after ack; GAP one idle bus cycle, then next word or IDLE when len=0.
REQ-020 Halfword address increments modulo 2^(AW+1); wrap from all-ones to 0 is legal and continues.
REQ-021 din beats while not in WFILL are ignored (din_ready=0); ack_i while cyc_o=0 is ignored.
REQ-022 Latency: request accept to first cyc_o=1 is 1 cycle (read) or 1 cycle after last fill beat (write).

Reset
REQ-023 rst_i high at an edge: state IDLE; cyc_o, stb_o, we_o, dout_valid, din_ready = 0; sel_o=0; dat_o=0; adr_o=0.
REQ-024 Reset mid-transaction abandons it immediately; cyc_o low the cycle after reset sampled; no further dout_valid.
REQ-025 req_ready=1 the first cycle after rst_i deasserts.

Structure
REQ-026 Shared package wb_req_pkg holds state encoding, default AW, halfword/word widths, length width.
REQ-027 No sub-module; single FSM with datapath registers.

Verification
REQ-028 Read addr=0x000010, len=2, slave dat_i=0xDEADBEEF -> one cycle adr_o=0x000008, dout 0xBEEF then 0xDEAD consecutive.
REQ-029 Write addr=0x000021, len=3, din 0x1111/0x2222/0x3333 mask 2'b11 -> cycle1 adr 0x10 sel 4'b1100 dat[31:16]=0x1111; cycle2 adr 0x11 sel 4'hF dat=0x33332222.
REQ-030 Write addr=0x000004, len=1, mask 2'b01, din 0x00AB -> single cycle adr 0x02, sel 4'b0001, dat[15:0]=0x00AB.
REQ-031 Read addr=all-ones, len=2 -> words adr_o=all-ones then 0; two dout beats; cyc_o gap of 1 between.
REQ-032 rst_i asserted while stb_o=1 awaiting ack -> next cycle cyc_o=0, req_ready=1 after deassert, late ack_i ignored.
REQ-033 len=0 request -> accepted, no cyc_o, req_ready stays 1.

Source files
------------

// File: rtl/wb_req_pkg.sv
// Shared constants for the halfword-request Wishbone master.
// Holds the state encoding, the default address width and the datapath widths.
package wb_req_pkg;

  localparam int AW_DEFAULT = 23;
  localparam int HW_W       = 16;
  localparam int WORD_W     = 32;
  localparam int SEL_W      = 4;
  localparam int LEN_W      = 4;
  localparam int STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WFILL = 3'd1;
  localparam logic [STATE_W-1:0] ST_WBUS  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RBUS  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RHI   = 3'd4;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd5;

endpackage

// File: rtl/wb_req_master.sv
// Converts halfword burst requests into Wishbone classic 32-bit word cycles.
// Writes pack up to two halfwords per word; reads unpack one word into one or two halfwords.
module wb_req_master
  import wb_req_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW:0]       req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_we,
  input  logic [HW_W-1:0]   din,
  input  logic [1:0]        din_mask,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [HW_W-1:0]   dout,
  output logic              dout_valid,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [AW-1:0]     adr_o,
  output logic [WORD_W-1:0] dat_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [WORD_W-1:0] dat_i,
  input  logic              ack_i
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               we_q, we_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [WORD_W-1:0]  dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [HW_W-1:0]    rdata_hi_q, rdata_hi_d;
  logic [HW_W-1:0]    dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [LEN_W-1:0]   len_dec;
  logic [AW:0]        addr_inc;

  // adr_q latches the word being worked on, since addr_q runs ahead after each halfword.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rdata_hi_d   = rdata_hi_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    len_dec      = len_q - 1'b1;
    addr_inc     = addr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          len_d  = req_len;
          we_d   = req_we;
          if (req_len != '0) begin
            if (req_we) begin
              state_d = ST_WFILL;
              dat_d   = '0;
              sel_d   = '0;
            end else begin
              state_d = ST_RBUS;
              adr_d   = req_addr[AW:1];
            end
          end
        end
      end
      ST_WFILL: begin
        if (din_valid) begin
          adr_d = addr_q[AW:1];
          if (addr_q[0]) begin
            dat_d[31:16] = din;
            sel_d[3:2]   = din_mask;
          end else begin
            dat_d[15:0] = din;
            sel_d[1:0]  = din_mask;
          end
          addr_d = addr_inc;
          len_d  = len_dec;
          if (addr_q[0] || (len_dec == '0)) state_d = ST_WBUS;
        end
      end
      ST_WBUS: begin
        if (ack_i) state_d = ST_GAP;
      end
      ST_RBUS: begin
        if (ack_i) begin
          rdata_hi_d   = dat_i[31:16];
          dout_d       = addr_q[0] ? dat_i[31:16] : dat_i[15:0];
          dout_valid_d = 1'b1;
          addr_d       = addr_inc;
          len_d        = len_dec;
          state_d      = (!addr_q[0] && (len_dec != '0)) ? ST_RHI : ST_GAP;
        end
      end
      ST_RHI: begin
        dout_d       = rdata_hi_q;
        dout_valid_d = 1'b1;
        addr_d       = addr_inc;
        len_d        = len_dec;
        state_d      = ST_GAP;
      end
      ST_GAP: begin
        if (len_q == '0) begin
          state_d = ST_IDLE;
        end else if (we_q) begin
          state_d = ST_WFILL;
          dat_d   = '0;
          sel_d   = '0;
        end else begin
          state_d = ST_RBUS;
          adr_d   = addr_q[AW:1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rdata_hi_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rdata_hi_q   <= rdata_hi_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign din_ready  = (state_q == ST_WFILL);
  assign cyc_o      = (state_q == ST_WBUS) || (state_q == ST_RBUS);
  assign stb_o      = cyc_o;
  assign we_o       = (state_q == ST_WBUS);
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign sel_o      = (state_q == ST_RBUS) ? 4'hF : sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
